// File: rtl/matrix_ring_scanner.sv
// rtl/matrix_ring_scanner.sv - three-slot column ring scanner with double-buffered row frame
//
// Purpose:
//   Drives a 3-column LED/keypad matrix. Each column slot lasts PRESCALE clocks:
//   BLANK clocks with all columns off, followed by PRESCALE-BLANK clocks with one
//   column selected (one-hot ring_counter) and its 7-bit row pattern on rows.
//   A new 21-bit frame is written into a pending buffer and swapped into the
//   active buffer only at a frame boundary, so a frame is never shown torn.
//
// Ports:
//   clock         in   single clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   enable        in   scan enable; low returns the scanner to IDLE
//   frame_load    in   write frame_data into the pending buffer
//   frame_data    in   [7k+6:7k] = row pattern for slot k, k = 0..2
//   frame_busy    out  pending buffer full; loads ignored while high
//   frame_ack     out  one-cycle pulse, load accepted
//   ring_counter  out  one-hot column select, 000 while blanked
//   rows          out  row pattern of the current slot, 0 while blanked
//   frame_sync    out  one-cycle pulse during the last DRIVE cycle of slot 2
//
// All outputs are registered. They are computed from the next-state values so
// that each output register reflects the state register it belongs to in the
// same cycle.

module matrix_ring_scanner #(
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        frame_load,
  input  logic [20:0] frame_data,
  output logic        frame_busy,
  output logic        frame_ack,
  output logic [2:0]  ring_counter,
  output logic [6:0]  rows,
  output logic        frame_sync
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  // Terminal counts of the two phases of a slot.
  localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
  localparam logic [15:0] DRIVE_LAST = 16'(PRESCALE - BLANK - 1);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [1:0]  slot;
  logic [20:0] active;
  logic [20:0] pending;

  logic [1:0]  state_n;
  logic [15:0] cnt_n;
  logic [1:0]  slot_n;
  logic        boundary;
  logic        swap;
  logic        accept;
  logic        busy_n;
  logic [20:0] active_n;
  logic [20:0] pending_n;
  logic [2:0]  ring_n;
  logic [6:0]  rows_n;
  logic        sync_n;

  // Scan sequencer.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    slot_n   = slot;
    boundary = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n  = 16'd0;
        slot_n = 2'd0;
        if (enable) begin
          state_n = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_n = ST_IDLE;
          cnt_n   = 16'd0;
          slot_n  = 2'd0;
        end else if (cnt == BLANK_LAST) begin
          state_n = ST_DRIVE;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_DRIVE: begin
        if (!enable) begin
          state_n = ST_IDLE;
          cnt_n   = 16'd0;
          slot_n  = 2'd0;
        end else if (cnt == DRIVE_LAST) begin
          state_n = ST_BLANK;
          cnt_n   = 16'd0;
          if (slot == 2'd2) begin
            slot_n   = 2'd0;
            boundary = 1'b1;
          end else begin
            slot_n = slot + 2'd1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = 16'd0;
        slot_n  = 2'd0;
      end
    endcase
  end

  // Frame buffers. A swap needs frame_busy high and a load needs it low, so
  // in a cycle with both requests the load is dropped and the swap proceeds.
  always_comb begin
    swap      = boundary && frame_busy;
    accept    = frame_load && !frame_busy;
    active_n  = swap ? pending : active;
    pending_n = accept ? frame_data : pending;
    busy_n    = frame_busy;
    if (swap) begin
      busy_n = 1'b0;
    end else if (accept) begin
      busy_n = 1'b1;
    end
  end

  // Output decode from next-state values, so the new frame already shows on
  // the first DRIVE of slot 0 after the swap.
  always_comb begin
    ring_n = 3'b000;
    rows_n = 7'd0;
    if (state_n == ST_DRIVE) begin
      case (slot_n)
        2'd0: begin
          ring_n = 3'b001;
          rows_n = active_n[6:0];
        end
        2'd1: begin
          ring_n = 3'b010;
          rows_n = active_n[13:7];
        end
        2'd2: begin
          ring_n = 3'b100;
          rows_n = active_n[20:14];
        end
        default: begin
          ring_n = 3'b000;
          rows_n = 7'd0;
        end
      endcase
    end
  end

  // frame_sync is raised one cycle ahead of the boundary edge so that it is
  // high in the same cycle as the swap decision.
  always_comb begin
    sync_n = (state_n == ST_DRIVE) && (slot_n == 2'd2) && (cnt_n == DRIVE_LAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= 16'd0;
      slot         <= 2'd0;
      active       <= 21'd0;
      pending      <= 21'd0;
      frame_busy   <= 1'b0;
      frame_ack    <= 1'b0;
      ring_counter <= 3'b000;
      rows         <= 7'd0;
      frame_sync   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      slot         <= slot_n;
      active       <= active_n;
      pending      <= pending_n;
      frame_busy   <= busy_n;
      frame_ack    <= accept;
      ring_counter <= ring_n;
      rows         <= rows_n;
      frame_sync   <= sync_n;
    end
  end

endmodule

// File: tb/tb_matrix_ring_scanner.sv
// tb/tb_matrix_ring_scanner.sv - table-driven bench for matrix_ring_scanner (PRESCALE=8, BLANK=2)

module tb_matrix_ring_scanner;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        frame_load;
  logic [20:0] frame_data;
  logic        frame_busy;
  logic        frame_ack;
  logic [2:0]  ring_counter;
  logic [6:0]  rows;
  logic        frame_sync;

  int checks;
  int errors;

  matrix_ring_scanner #(.PRESCALE(8), .BLANK(2)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .frame_load   (frame_load),
    .frame_data   (frame_data),
    .frame_busy   (frame_busy),
    .frame_ack    (frame_ack),
    .ring_counter (ring_counter),
    .rows         (rows),
    .frame_sync   (frame_sync)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic        ld;
    logic [20:0] d;
    int          n;
    logic [2:0]  ring;
    logic [6:0]  rows;
    logic        sync;
    logic        ack;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, input logic ld, input logic [20:0] d, input int n,
                     input logic [2:0] ring, input logic [6:0] r, input logic sync,
                     input logic ack, input logic busy);
    vec_t v;
    v.en = en; v.ld = ld; v.d = d; v.n = n;
    v.ring = ring; v.rows = r; v.sync = sync; v.ack = ack; v.busy = busy;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int step, input logic [2:0] ring,
                           input logic [6:0] r, input logic sync, input logic ack, input logic busy);
    check({tag, ".ring_counter"}, step, 32'(ring_counter), 32'(ring));
    check({tag, ".rows"},         step, 32'(rows),         32'(r));
    check({tag, ".frame_sync"},   step, 32'(frame_sync),   32'(sync));
    check({tag, ".frame_ack"},    step, 32'(frame_ack),    32'(ack));
    check({tag, ".frame_busy"},   step, 32'(frame_busy),   32'(busy));
  endtask

  initial begin
    int step;
    checks = 0;
    errors = 0;
    step   = 0;

    // Frame A = 0x1FC07F -> slots 7F,00,7F. Frame B = 0x003F80 -> slots 00,7F,00.
    //  en ld data       n  ring    rows   sy ack busy
    add(0, 1, 21'h1FC07F, 1, 3'b000, 7'h00, 0, 1, 1); // load in IDLE
    add(0, 0, 21'h0,      1, 3'b000, 7'h00, 0, 0, 1);
    add(1, 1, 21'h155555, 1, 3'b000, 7'h00, 0, 0, 1); // load while busy: ignored
    add(1, 0, 21'h0,      1, 3'b000, 7'h00, 0, 0, 1);
    add(1, 0, 21'h0,      6, 3'b001, 7'h00, 0, 0, 1); // first frame still blank rows
    add(1, 0, 21'h0,      2, 3'b000, 7'h00, 0, 0, 1);
    add(1, 0, 21'h0,      6, 3'b010, 7'h00, 0, 0, 1);
    add(1, 0, 21'h0,      2, 3'b000, 7'h00, 0, 0, 1);
    add(1, 0, 21'h0,      5, 3'b100, 7'h00, 0, 0, 1);
    add(1, 0, 21'h0,      1, 3'b100, 7'h00, 1, 0, 1); // frame_sync, busy still high
    add(1, 1, 21'h0AAAAA, 1, 3'b000, 7'h00, 0, 0, 0); // load on sync cycle: swap wins
    add(1, 1, 21'h003F80, 1, 3'b000, 7'h00, 0, 1, 1); // load after swap: accepted
    add(1, 0, 21'h0,      6, 3'b001, 7'h7F, 0, 0, 1);
    add(1, 0, 21'h0,      2, 3'b000, 7'h00, 0, 0, 1);
    add(1, 0, 21'h0,      6, 3'b010, 7'h00, 0, 0, 1);
    add(1, 0, 21'h0,      2, 3'b000, 7'h00, 0, 0, 1);
    add(1, 0, 21'h0,      5, 3'b100, 7'h7F, 0, 0, 1);
    add(1, 0, 21'h0,      1, 3'b100, 7'h7F, 1, 0, 1);
    add(1, 0, 21'h0,      2, 3'b000, 7'h00, 0, 0, 0); // swap to frame B
    add(1, 0, 21'h0,      6, 3'b001, 7'h00, 0, 0, 0);
    add(1, 0, 21'h0,      2, 3'b000, 7'h00, 0, 0, 0);
    add(1, 0, 21'h0,      3, 3'b010, 7'h7F, 0, 0, 0);
    add(0, 0, 21'h0,      1, 3'b000, 7'h00, 0, 0, 0); // enable dropped mid-DRIVE slot 1
    add(0, 0, 21'h0,      2, 3'b000, 7'h00, 0, 0, 0);
    add(1, 0, 21'h0,      2, 3'b000, 7'h00, 0, 0, 0); // restart at BLANK of slot 0
    add(1, 0, 21'h0,      6, 3'b001, 7'h00, 0, 0, 0);
    add(1, 0, 21'h0,      2, 3'b000, 7'h00, 0, 0, 0);
    add(1, 0, 21'h0,      6, 3'b010, 7'h7F, 0, 0, 0); // frame B preserved

    reset_n    = 1'b0;
    enable     = 1'b0;
    frame_load = 1'b0;
    frame_data = 21'h0;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset", 0, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        enable     = tbl[i].en;
        frame_load = tbl[i].ld && (k == 0);
        frame_data = tbl[i].d;
        @(posedge clock);
        #1;
        step++;
        check_all($sformatf("row%0d", i), step, tbl[i].ring, tbl[i].rows,
                  tbl[i].sync, tbl[i].ack, tbl[i].busy);
      end
    end

    // Asynchronous reset in the middle of a DRIVE phase.
    frame_load = 1'b0;
    enable     = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_all("pre_reset", 1000, 3'b100, 7'h00, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_reset", 1001, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // Scanning resumes from BLANK of slot 0 with the active frame cleared.
    @(posedge clock);
    #1;
    check_all("post_reset_blank", 1002, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check_all("post_reset_slot0", 1003, 3'b001, 7'h00, 1'b0, 1'b0, 1'b0);
    repeat (8) @(posedge clock);
    #1;
    check_all("post_reset_slot1", 1004, 3'b010, 7'h00, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
